efuse_readout: RTL and testbench

//   Downstream companion of the eFuse control state machine in read mode.

---
 rtl/efuse_readout.sv | 106 ++++++++++
 tb/tb_efuse_readout.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/efuse_readout.sv
// efuse_readout: samples the eFuse serial output on each SCLK fall during a read
// and presents the assembled word with a valid pulse, sticky abort error and compare flag.
`default_nettype none

module efuse_readout #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CSB,
  input  logic             PGM,
  input  logic             SCLK,
  input  logic             efuse_q,
  input  logic [WIDTH-1:0] expect_word,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             err,
  output logic             match
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-2:0] sr;
  logic             sclk_d;
  logic             csb_d;

  logic             fall;
  logic             start;
  logic [WIDTH-1:0] word;

  // SCLK and CSB are produced in this clock domain, so plain delayed copies suffice.
  assign fall  = sclk_d & ~SCLK;
  assign start = csb_d & ~CSB & ~PGM;
  assign word  = {efuse_q, sr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      sclk_d     <= 1'b0;
      csb_d      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      match      <= 1'b0;
    end else begin
      sclk_d     <= SCLK;
      csb_d      <= CSB;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            sr    <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          // A deselect or program-mode switch wins over a coincident fall.
          if (CSB || PGM) begin
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (fall) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              data_out   <= word;
              match      <= (word == expect_word);
              data_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              sr[cnt] <= efuse_q;
            end
          end
        end
        DONE: begin
          if (CSB) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_efuse_readout.sv
// Scoreboard bench for efuse_readout: directed reads push expected words, a monitor checks each valid.
`default_nettype none

module tb_efuse_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        CSB;
  logic        PGM;
  logic        SCLK;
  logic        efuse_q;
  logic [31:0] expect_word;
  logic [31:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        err;
  logic        match;

  int tests  = 0;
  int failed = 0;

  // Each entry is {match, data}.
  logic [32:0] exp_q[$];
  logic        prev_valid = 1'b0;

  efuse_readout #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .CSB        (CSB),
    .PGM        (PGM),
    .SCLK       (SCLK),
    .efuse_q    (efuse_q),
    .expect_word(expect_word),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err),
    .match      (match)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every valid must match the head of the scoreboard and last only one cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && data_valid === 1'b1) begin
      if (prev_valid) begin
        check("valid_pulse_width", 32'd2, 32'd1);
      end
      if (exp_q.size() == 0) begin
        check("unexpected_valid", data_out, 32'hxxxx_xxxx);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_data", data_out, e[31:0]);
        check("sb_match", {31'd0, match}, {31'd0, e[32]});
      end
    end
    prev_valid <= (rst === 1'b1) && (data_valid === 1'b1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_read();
    CSB = 1'b1;
    tick(1);
    CSB = 1'b0;
    tick(2);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      efuse_q = w[i];
      SCLK    = 1'b1;
      tick(2);
      SCLK    = 1'b0;
      tick(2);
    end
  endtask

  task automatic end_read();
    CSB = 1'b1;
    tick(2);
  endtask

  initial begin
    rst         = 1'b0;
    CSB         = 1'b1;
    PGM         = 1'b0;
    SCLK        = 1'b0;
    efuse_q     = 1'b0;
    expect_word = 32'h0;
    tick(3);
    @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_match", {31'd0, match}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);

    // 1: matching read
    expect_word = 32'hA5A5_0F3C;
    exp_q.push_back({1'b1, 32'hA5A5_0F3C});
    start_read();
    check("t1_busy", {31'd0, busy}, 32'd1);
    shift_bits(32'hA5A5_0F3C, 32);
    check("t1_busy_done", {31'd0, busy}, 32'd0);
    check("t1_err", {31'd0, err}, 32'd0);
    end_read();

    // 2: LSB-first, mismatch
    expect_word = 32'h0000_0000;
    exp_q.push_back({1'b0, 32'h0000_0001});
    start_read();
    shift_bits(32'h0000_0001, 32);
    end_read();

    // 3: deselect after 17 falls, then a good read clears err
    start_read();
    shift_bits(32'hFFFF_FFFF, 17);
    CSB = 1'b1;
    tick(2);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_hold", data_out, 32'h0000_0001);
    check("t3_busy", {31'd0, busy}, 32'd0);
    expect_word = 32'h1234_5679;
    exp_q.push_back({1'b0, 32'h1234_5678});
    start_read();
    check("t3_err_clr", {31'd0, err}, 32'd0);
    shift_bits(32'h1234_5678, 32);
    end_read();

    // 4: program-mode switch mid-read
    start_read();
    shift_bits(32'h0000_FFFF, 10);
    PGM = 1'b1;
    tick(2);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_hold", data_out, 32'h1234_5678);
    PGM = 1'b0;
    end_read();

    // 5: extra falls after a complete word are ignored
    expect_word = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    start_read();
    shift_bits(32'hDEAD_BEEF, 32);
    shift_bits(32'h0000_0005, 3);
    check("t5_hold", data_out, 32'hDEAD_BEEF);
    check("t5_err", {31'd0, err}, 32'd0);
    end_read();

    // 6: reset at bit 10, then a full read
    start_read();
    shift_bits(32'h0000_0000, 10);
    rst = 1'b0;
    CSB = 1'b1;
    @(negedge clk);
    check("t6_rst_data", data_out, 32'h0);
    check("t6_rst_match", {31'd0, match}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);
    expect_word = 32'hFFFF_FFFF;
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    start_read();
    shift_bits(32'hFFFF_FFFF, 32);
    end_read();

    tick(4);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
